tile_sched: RTL

TILE_SCHED -- requirements
Module: tile_sched

---
 rtl/tile_sched.sv | 94 +++++++++
 1 files changed

// File: rtl/tile_sched.sv
// tile_sched: walks a num_rows x num_cols matrix in row-major J x K tiles, issuing tile origins over a valid/ready handshake.
module tile_sched #(
    parameter int J = 2,
    parameter int K = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [9:0] num_rows,
    input  logic [9:0] num_cols,
    input  logic       tile_ready,
    output logic       tile_valid,
    output logic [9:0] start_row,
    output logic [9:0] start_col,
    output logic       last_tile,
    output logic [9:0] tile_idx,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, ISSUE, FIN} state_t;
    state_t state, state_n;
    logic [9:0] rows, cols, rows_n, cols_n, row_n, col_n, idx_n;
    logic [10:0] row_nx, col_nx;
    logic hs, last_n;
    assign hs = tile_valid & tile_ready;
    assign row_nx = {1'b0, start_row} + 11'(J);
    assign col_nx = {1'b0, start_col} + 11'(K);
    always_comb begin
        state_n = state;
        rows_n = rows;
        cols_n = cols;
        row_n = start_row;
        col_n = start_col;
        idx_n = tile_idx;
        if (abort)
            state_n = IDLE;
        else
            case (state)
                IDLE: if (start) begin
                    if (num_rows != 10'd0 && num_cols != 10'd0) begin
                        rows_n = num_rows;
                        cols_n = num_cols;
                        row_n = 10'd0;
                        col_n = 10'd0;
                        idx_n = 10'd0;
                        state_n = ISSUE;
                    end else
                        state_n = FIN;
                end
                ISSUE: if (hs) begin
                    idx_n = tile_idx + 10'd1;
                    if (col_nx < {1'b0, cols})
                        col_n = col_nx[9:0];
                    else if (row_nx < {1'b0, rows}) begin
                        col_n = 10'd0;
                        row_n = row_nx[9:0];
                    end else
                        state_n = FIN;
                end
                FIN: state_n = IDLE;
                default: state_n = IDLE;
            endcase
    end
    // last flag is evaluated on the origin that will be presented next cycle
    assign last_n = (state_n == ISSUE)
                  && ({1'b0, row_n} + 11'(J) >= {1'b0, rows_n})
                  && ({1'b0, col_n} + 11'(K) >= {1'b0, cols_n});
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rows <= 10'd0;
            cols <= 10'd0;
            start_row <= 10'd0;
            start_col <= 10'd0;
            tile_idx <= 10'd0;
            tile_valid <= 1'b0;
            last_tile <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            rows <= rows_n;
            cols <= cols_n;
            start_row <= row_n;
            start_col <= col_n;
            tile_idx <= idx_n;
            tile_valid <= state_n == ISSUE;
            last_tile <= last_n;
            busy <= state_n == ISSUE;
            done <= state_n == FIN;
        end
    end
endmodule
